// File: rtl/aha_loop_back_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aha_loop_back_pkg                                                     |
// | Shared state types and timing constants for the loopback monitor.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package aha_loop_back_pkg;

   localparam int SYNC_STAGES  = 2;
   localparam int FLUSH_CYCLES = 3;

   typedef enum logic [0:0] {
      ACTIVE = 1'b0,
      BLANK  = 1'b1
   } sel_state_t;

   typedef enum logic [1:0] {
      M_IDLE  = 2'd0,
      M_FLUSH = 2'd1,
      M_COUNT = 2'd2
   } meas_state_t;

endpackage
`default_nettype wire

// File: rtl/aha_loop_back_mon_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aha_loop_back_mon_if                                                  |
// | Select/measure control and observation bus of the loopback monitor.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface aha_loop_back_mon_if #(
   parameter int NUM_CH = 16,
   parameter int SEL_W  = 4,
   parameter int WIN_W  = 16,
   parameter int CNT_W  = 16
);
   logic [NUM_CH-1:0] SIGNALS_IN;
   logic              SEL_REQ;
   logic [SEL_W-1:0]  SEL_CH;
   logic              SEL_ACK;
   logic [SEL_W-1:0]  CUR_SEL;
   logic              MEAS_START;
   logic [WIN_W-1:0]  WINDOW;
   logic              MEAS_BUSY;
   logic              MEAS_DONE;
   logic              MEAS_ABORT;
   logic [CNT_W-1:0]  EDGE_COUNT;
   logic              EDGE_SAT;
   logic              LOOP_BACK;

   modport master (
      output SIGNALS_IN, SEL_REQ, SEL_CH, MEAS_START, WINDOW,
      input  SEL_ACK, CUR_SEL, MEAS_BUSY, MEAS_DONE, MEAS_ABORT,
             EDGE_COUNT, EDGE_SAT, LOOP_BACK
   );

   modport slave (
      input  SIGNALS_IN, SEL_REQ, SEL_CH, MEAS_START, WINDOW,
      output SEL_ACK, CUR_SEL, MEAS_BUSY, MEAS_DONE, MEAS_ABORT,
             EDGE_COUNT, EDGE_SAT, LOOP_BACK
   );
endinterface
`default_nettype wire

// File: rtl/aha_sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aha_sync_2ff                                                          |
// | Single-bit multi-flop synchroniser with async active-high reset.      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module aha_sync_2ff
   import aha_loop_back_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);
   logic [SYNC_STAGES-1:0] r_stage;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stage <= '0;
      end else begin
         r_stage <= {r_stage[SYNC_STAGES-2:0], i_d};
      end
   end

   assign o_q = r_stage[SYNC_STAGES-1];
endmodule
`default_nettype wire

// File: rtl/aha_loop_back_mon.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aha_loop_back_mon                                                     |
// | Glitch-guarded loopback channel select plus windowed edge counter.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module aha_loop_back_mon
   import aha_loop_back_pkg::*;
#(
   parameter int NUM_CH       = 16,
   parameter int SEL_W        = 4,
   parameter int RESET_SEL    = 0,
   parameter int BLANK_CYCLES = 4,
   parameter int WIN_W        = 16,
   parameter int CNT_W        = 16
) (
   input  logic               CLK,
   input  logic               RESET,
   aha_loop_back_mon_if.slave bus
);
   localparam int                  c_bcnt_w     = $clog2(BLANK_CYCLES);
   localparam logic [c_bcnt_w-1:0] c_blank_last = c_bcnt_w'(BLANK_CYCLES - 1);
   localparam logic [WIN_W-1:0]    c_flush_last = WIN_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0]    c_cnt_max    = '1;

   sel_state_t          r_sel_state;
   logic                r_armed;
   logic                r_blank;
   logic                r_sel_ack;
   logic [SEL_W-1:0]    r_cur_sel;
   logic [SEL_W-1:0]    r_pend_sel;
   logic [c_bcnt_w-1:0] r_blank_cnt;

   meas_state_t         r_meas_state;
   logic [WIN_W-1:0]    r_window;
   logic [WIN_W-1:0]    r_phase_cnt;
   logic [CNT_W-1:0]    r_edge_count;
   logic                r_edge_sat;
   logic                r_meas_done;
   logic                r_sync_prev;

   logic w_sel_sig, w_loop_back, w_sync, w_rise, w_accept, w_start, w_busy;

   // Out-of-range selects match no channel and leave the mux output low.
   always_comb begin
      w_sel_sig = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_cur_sel == SEL_W'(i)) w_sel_sig = bus.SIGNALS_IN[i];
      end
   end

   assign w_loop_back = w_sel_sig & ~r_blank;
   assign w_accept    = (r_sel_state == ACTIVE) && r_armed && bus.SEL_REQ;
   assign w_busy      = (r_meas_state != M_IDLE);
   assign w_start     = bus.MEAS_START && !w_busy && (r_sel_state == ACTIVE) && !w_accept;
   assign w_rise      = w_sync & ~r_sync_prev;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_sel_state <= ACTIVE;
         r_armed     <= 1'b1;
         r_blank     <= 1'b0;
         r_sel_ack   <= 1'b0;
         r_cur_sel   <= SEL_W'(RESET_SEL);
         r_pend_sel  <= SEL_W'(RESET_SEL);
         r_blank_cnt <= '0;
      end else begin
         r_sel_ack <= 1'b0;
         case (r_sel_state)
            ACTIVE: begin
               if (!bus.SEL_REQ) r_armed <= 1'b1;
               if (w_accept) begin
                  r_armed     <= 1'b0;
                  r_pend_sel  <= bus.SEL_CH;
                  r_blank     <= 1'b1;
                  r_blank_cnt <= '0;
                  r_sel_state <= BLANK;
               end
            end
            BLANK: begin
               r_blank_cnt <= r_blank_cnt + c_bcnt_w'(1);
               // Switch the mux one cycle into the blank so the pad is already low.
               if (r_blank_cnt == '0) r_cur_sel <= r_pend_sel;
               if (r_blank_cnt == c_blank_last) begin
                  r_blank     <= 1'b0;
                  r_sel_ack   <= 1'b1;
                  r_sel_state <= ACTIVE;
               end
            end
         endcase
      end
   end

   aha_sync_2ff u_sync (
      .clk (CLK),
      .rst (RESET),
      .i_d (w_loop_back),
      .o_q (w_sync)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_meas_state <= M_IDLE;
         r_window     <= '0;
         r_phase_cnt  <= '0;
         r_edge_count <= '0;
         r_edge_sat   <= 1'b0;
         r_meas_done  <= 1'b0;
         r_sync_prev  <= 1'b0;
      end else begin
         r_meas_done <= 1'b0;
         r_sync_prev <= w_sync;
         if (w_accept && w_busy) begin
            r_meas_state <= M_IDLE;
         end else begin
            case (r_meas_state)
               M_IDLE: begin
                  if (w_start) begin
                     r_meas_state <= M_FLUSH;
                     r_window     <= bus.WINDOW;
                     r_phase_cnt  <= '0;
                     r_edge_count <= '0;
                     r_edge_sat   <= 1'b0;
                  end
               end
               M_FLUSH: begin
                  // Edge history keeps updating here but nothing is counted.
                  r_phase_cnt <= r_phase_cnt + WIN_W'(1);
                  if (r_phase_cnt == c_flush_last) begin
                     r_phase_cnt <= '0;
                     if (r_window == '0) begin
                        r_meas_done  <= 1'b1;
                        r_meas_state <= M_IDLE;
                     end else begin
                        r_meas_state <= M_COUNT;
                     end
                  end
               end
               M_COUNT: begin
                  if (w_rise) begin
                     if (r_edge_count == c_cnt_max) r_edge_sat <= 1'b1;
                     else r_edge_count <= r_edge_count + CNT_W'(1);
                  end
                  r_phase_cnt <= r_phase_cnt + WIN_W'(1);
                  if (r_phase_cnt == r_window - WIN_W'(1)) begin
                     r_meas_done  <= 1'b1;
                     r_meas_state <= M_IDLE;
                  end
               end
               default: r_meas_state <= M_IDLE;
            endcase
         end
      end
   end

   assign bus.SEL_ACK    = r_sel_ack;
   assign bus.CUR_SEL    = r_cur_sel;
   assign bus.MEAS_BUSY  = w_busy;
   assign bus.MEAS_DONE  = r_meas_done;
   assign bus.MEAS_ABORT = w_accept & w_busy;
   assign bus.EDGE_COUNT = r_edge_count;
   assign bus.EDGE_SAT   = r_edge_sat;
   assign bus.LOOP_BACK  = w_loop_back;
endmodule
`default_nettype wire
